// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter between instruction fetch (IF) and load/store (LSB) ports.
// One transfer at a time; LSB is favoured, with a bounded starvation limit for IF.
module mem_arbiter #(
    parameter logic [1:0]  IO_HI      = 2'b11,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned KW     = 3;
    localparam int unsigned LOSS_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d, n_q, n_d, k_inc;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                own_if_q, own_if_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]       asm_q, asm_d;
    logic                mem_wr_q, mem_wr_d;
    logic [AW-1:0]       mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                if_done_q, if_done_d;
    logic                lsb_done_q, lsb_done_d;
    logic [DW-1:0]       if_data_q, if_data_d;
    logic [DW-1:0]       lsb_rdata_q, lsb_rdata_d;
    logic                grant_if;
    logic [1:0]          byte_idx;

    function automatic logic [KW-1:0] len_bytes(input logic [1:0] len);
        return len[1] ? KW'(4) : (len[0] ? KW'(2) : KW'(1));
    endfunction

    // A store to the IO region must wait while the IO sink is full.
    function automatic logic io_block(input logic full, input logic [AW-1:0] a);
        return full && (a[17:16] == IO_HI);
    endfunction

    assign k_inc = k_q + KW'(1);

    // Next-state and registered-output logic; rdy low freezes everything and drops mem_wr.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        loss_d      = loss_q;
        own_if_d    = own_if_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        mem_wr_d    = 1'b0;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        if_done_d   = if_done_q;
        lsb_done_d  = lsb_done_q;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;
        grant_if    = 1'b0;
        byte_idx    = 2'(k_q - KW'(1));

        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (if_req || lsb_req) begin
                        grant_if = if_req && (!lsb_req || (loss_q >= LOSS_W'(STARVE_MAX)));
                        own_if_d = grant_if;
                        k_d      = '0;
                        asm_d    = '0;
                        if (grant_if) begin
                            loss_d  = '0;
                            addr_d  = if_addr;
                            n_d     = KW'(4);
                            mem_a_d = if_addr;
                            state_d = READ;
                        end else begin
                            if (if_req) loss_d = LOSS_W'(loss_q + LOSS_W'(1));
                            addr_d  = lsb_addr;
                            wdata_d = lsb_wdata;
                            n_d     = len_bytes(lsb_len);
                            mem_a_d = lsb_addr;
                            if (lsb_wr) begin
                                state_d = WRITE;
                                if (!io_block(io_buffer_full, lsb_addr)) begin
                                    mem_wr_d   = 1'b1;
                                    mem_dout_d = lsb_wdata[7:0];
                                    k_d        = KW'(1);
                                end
                            end else begin
                                state_d = READ;
                            end
                        end
                    end
                end
                // k counts edges since grant: address k+1 goes out, byte k-1 comes back.
                READ: begin
                    if (k_q != '0) asm_d[{byte_idx, 3'b000} +: 8] = mem_din;
                    if (k_q == n_q) begin
                        state_d = DONE;
                        if (own_if_q) begin
                            if_done_d = 1'b1;
                            if_data_d = asm_d;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = asm_d;
                        end
                    end else begin
                        k_d = k_inc;
                        if (k_inc < n_q) mem_a_d = addr_q + AW'(k_inc);
                    end
                end
                // k is the next byte to issue.
                WRITE: begin
                    if (k_q == n_q) begin
                        state_d    = DONE;
                        lsb_done_d = 1'b1;
                    end else if (!io_block(io_buffer_full, addr_q)) begin
                        mem_wr_d   = 1'b1;
                        mem_a_d    = addr_q + AW'(k_q);
                        mem_dout_d = wdata_q[{k_q[1:0], 3'b000} +: 8];
                        k_d        = k_inc;
                    end
                end
                DONE: begin
                    state_d    = IDLE;
                    k_d        = '0;
                    if_done_d  = 1'b0;
                    lsb_done_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            n_q         <= '0;
            loss_q      <= '0;
            own_if_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            mem_wr_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            loss_q      <= loss_d;
            own_if_q    <= own_if_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            mem_wr_q    <= mem_wr_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            if_done_q   <= if_done_d;
            lsb_done_q  <= lsb_done_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign if_done   = if_done_q;
    assign lsb_done  = lsb_done_q;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios plus randomized transactions
// checked against a transaction-level model of memory contents and arbitration.
module tb_mem_arbiter;
    localparam int unsigned STARVE_MAX = 2;
    localparam logic [1:0]  IO_HI      = 2'b11;

    logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req = 1'b0, lsb_wr = 1'b0;
    logic [1:0]  lsb_len = '0;
    logic [31:0] lsb_addr = '0, lsb_wdata = '0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_mode = 1'b0;

    logic [7:0]  wmap [logic [31:0]];
    logic [39:0] wr_log [$];

    mem_arbiter #(.IO_HI(IO_HI), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // Unwritten locations hold an address-derived pattern.
    function automatic logic [7:0] rd(input logic [31:0] a);
        logic [31:0] h;
        if (wmap.exists(a)) return wmap[a];
        h = a * 32'd2654435761;
        return h[31:24];
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = rd(a + 32'(i));
        return r;
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        return len[1] ? 4 : (len[0] ? 2 : 1);
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a = $urandom();
        case ($urandom_range(3))
            0:       return a;
            1:       return 32'hFFFF_FFFC + 32'($urandom_range(3));
            2:       return {a[31:18], IO_HI, a[15:0]};
            default: return {24'h0, a[7:0]};
        endcase
    endfunction

    // Synchronous RAM, one cycle read latency; its read pipeline stalls with rdy.
    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            wmap[mem_a] = mem_dout;
            wr_log.push_back({mem_a, mem_dout});
        end
        if (rdy) mem_din <= rd(mem_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    always @(negedge clk)
        if (if_done || lsb_done) check("done_onehot", 32'({if_done, lsb_done}), 32'(if_done ? 2 : 1));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (rnd_mode) begin
            rdy            = ($urandom_range(4) != 0);
            io_buffer_full = ($urandom_range(3) == 0);
        end
    endtask

    task automatic wait_done(output bit got_if);
        got_if = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (if_done || lsb_done) begin
                got_if = if_done;
                return;
            end
        end
        check("done_timeout", 32'(if_done | lsb_done), 32'd1);
        finish_tb();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!if_done && !lsb_done) return;
            step();
        end
        check("done_stuck", 32'({if_done, lsb_done}), 32'd0);
        finish_tb();
    endtask

    task automatic check_writes(input logic [31:0] a, input logic [31:0] wd, input int n);
        check("wr_count", 32'(wr_log.size()), 32'(n));
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            check("wr_addr", wr_log[i][39:8], a + 32'(i));
            check("wr_data", 32'(wr_log[i][7:0]), 32'(wd[8*i +: 8]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_wr"},    32'(mem_wr),   32'd0);
        check({tag, "_mem_a"},     mem_a,         32'd0);
        check({tag, "_mem_dout"},  32'(mem_dout), 32'd0);
        check({tag, "_if_done"},   32'(if_done),  32'd0);
        check({tag, "_lsb_done"},  32'(lsb_done), 32'd0);
        check({tag, "_if_data"},   if_data,       32'd0);
        check({tag, "_lsb_rdata"}, lsb_rdata,     32'd0);
    endtask

    initial begin
        bit          got, exp_if, pend_if, if_act;
        bit [5:0]    pat;
        int          lsb_cnt, li, n;
        int unsigned loss_m;
        logic        op_wr [4];
        logic [1:0]  op_len [4];
        logic [31:0] op_a [4];
        logic [31:0] op_wd [4];

        #1 rst = 1'b1;
        #1 check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fetch of 0x100: address walk, 5-cycle latency, little-endian data.
        wmap[32'h100] = 8'h13; wmap[32'h101] = 8'h00; wmap[32'h102] = 8'h00; wmap[32'h103] = 8'h00;
        if_addr = 32'h100;
        if_req  = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            if (e < 4) begin
                check("if_mem_a", mem_a, 32'h100 + 32'(e));
                check("if_mem_wr", 32'(mem_wr), 32'd0);
            end
            check("if_done_time", 32'(if_done), 32'(e == 5));
        end
        check("if_data", if_data, 32'h13);
        if_req = 1'b0;
        step();
        check("if_done_end", 32'(if_done), 32'd0);

        // Two-byte store.
        wr_log.delete();
        lsb_wr = 1'b1; lsb_len = 2'b01; lsb_addr = 32'h200; lsb_wdata = 32'hAABBCCDD; lsb_req = 1'b1;
        step();
        check("st2_wr0", 32'({mem_wr, mem_a, mem_dout}), 32'({1'b1, 32'h200, 8'hDD}));
        check("st2_a0", mem_a, 32'h200);
        step();
        check("st2_a1", mem_a, 32'h201);
        check("st2_d1", 32'({mem_wr, mem_dout}), 32'h1CC);
        check("st2_nodone", 32'(lsb_done), 32'd0);
        step();
        check("st2_done", 32'({mem_wr, lsb_done}), 32'd1);
        lsb_req = 1'b0;
        step();
        check_writes(32'h200, 32'hAABBCCDD, 2);

        // IO-region store held off by a full IO buffer.
        wr_log.delete();
        io_buffer_full = 1'b1;
        lsb_len = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'h1234565A; lsb_req = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            check("io_hold_wr", 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        step();
        check("io_wr", 32'({mem_wr, mem_dout}), 32'h15A);
        check("io_a", mem_a, 32'h30000);
        check("io_nodone", 32'(lsb_done), 32'd0);
        step();
        check("io_done", 32'({mem_wr, lsb_done}), 32'd1);
        lsb_req = 1'b0;
        step();
        check_writes(32'h30000, 32'h1234565A, 1);

        // Full IO buffer does not affect a store outside the IO region.
        io_buffer_full = 1'b1; lsb_addr = 32'h20000; lsb_req = 1'b1;
        step();
        check("nonio_wr", 32'(mem_wr), 32'd1);
        step();
        check("nonio_done", 32'(lsb_done), 32'd1);
        lsb_req = 1'b0; io_buffer_full = 1'b0;
        step();

        // Four-byte store with a two-cycle rdy stall, then a stalled done.
        wr_log.delete();
        lsb_len = 2'b10; lsb_addr = 32'h400; lsb_wdata = 32'h11223344; lsb_req = 1'b1;
        step();
        check("stall_a0", mem_a, 32'h400);
        check("stall_d0", 32'({mem_wr, mem_dout}), 32'h144);
        step();
        check("stall_a1", mem_a, 32'h401);
        check("stall_d1", 32'({mem_wr, mem_dout}), 32'h133);
        rdy = 1'b0;
        for (int e = 0; e < 2; e++) begin
            step();
            check("stall_wr", 32'(mem_wr), 32'd0);
            check("stall_a", mem_a, 32'h401);
        end
        rdy = 1'b1;
        step();
        check("stall_a2", mem_a, 32'h402);
        check("stall_d2", 32'({mem_wr, mem_dout}), 32'h122);
        step();
        check("stall_a3", mem_a, 32'h403);
        check("stall_d3", 32'({mem_wr, mem_dout}), 32'h111);
        step();
        check("stall_done", 32'({mem_wr, lsb_done}), 32'd1);
        lsb_req = 1'b0; rdy = 1'b0;
        step();
        check("done_held", 32'({mem_wr, lsb_done}), 32'd1);
        rdy = 1'b1;
        step();
        check("done_release", 32'(lsb_done), 32'd0);
        check_writes(32'h400, 32'h11223344, 4);

        // Both requesters held high: LSB, LSB, IF repeating.
        pat = 6'b100100;
        lsb_wr = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h500; if_addr = 32'h600;
        if_req = 1'b1; lsb_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            wait_done(got);
            check("starve_order", 32'(got), 32'(pat[g]));
            if (got) check("starve_if_data", if_data, exp_read(32'h600, 4));
            else     check("starve_lsb_data", lsb_rdata, exp_read(32'h500, 4));
            if (g == 5) begin
                if_req = 1'b0;
                lsb_req = 1'b0;
            end
        end
        step();

        // Reset in the middle of a 4-byte load.
        lsb_len = 2'b10; lsb_addr = 32'h700; lsb_req = 1'b1;
        step(); step(); step();
        check("pre_rst_a", mem_a, 32'h702);
        rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        lsb_req = 1'b0;
        for (int e = 0; e < 2; e++) begin
            step();
            check("rst_no_done", 32'({lsb_done, if_done, mem_wr}), 32'd0);
        end
        rst = 1'b0;
        if_addr = 32'h104; if_req = 1'b1;
        wait_done(got);
        check("post_rst_grant", 32'(got), 32'd1);
        check("post_rst_data", if_data, exp_read(32'h104, 4));
        if_req = 1'b0;
        step();

        // Randomized transactions with random stalls and IO back-pressure.
        rnd_mode = 1'b1;
        loss_m   = 0;
        for (int r = 0; r < 80; r++) begin
            if_act  = 1'($urandom_range(1));
            lsb_cnt = int'($urandom_range(3));
            if (!if_act && lsb_cnt == 0) lsb_cnt = 1;
            for (int i = 0; i < 4; i++) begin
                op_wr[i]  = 1'($urandom_range(1));
                op_len[i] = 2'($urandom_range(3));
                op_a[i]   = rnd_addr();
                op_wd[i]  = $urandom();
            end
            if_addr = rnd_addr();
            if_req  = if_act;
            pend_if = if_act;
            li      = 0;
            lsb_wr = op_wr[0]; lsb_len = op_len[0]; lsb_addr = op_a[0]; lsb_wdata = op_wd[0];
            lsb_req = (lsb_cnt > 0);
            while (pend_if || li < lsb_cnt) begin
                if (pend_if && li < lsb_cnt) exp_if = (loss_m >= STARVE_MAX);
                else                         exp_if = pend_if;
                if (exp_if)       loss_m = 0;
                else if (pend_if) loss_m++;
                wr_log.delete();
                wait_done(got);
                check("rnd_grant", 32'(got), 32'(exp_if));
                if (got) begin
                    check("rnd_if_data", if_data, exp_read(if_addr, 4));
                    check("rnd_if_nowr", 32'(wr_log.size()), 32'd0);
                    pend_if = 1'b0;
                    if_req  = 1'b0;
                end else begin
                    n = nbytes(op_len[li]);
                    if (op_wr[li]) begin
                        check_writes(op_a[li], op_wd[li], n);
                    end else begin
                        check("rnd_lsb_data", lsb_rdata, exp_read(op_a[li], n));
                        check("rnd_lsb_nowr", 32'(wr_log.size()), 32'd0);
                    end
                    li++;
                    if (li < lsb_cnt) begin
                        lsb_wr = op_wr[li]; lsb_len = op_len[li]; lsb_addr = op_a[li]; lsb_wdata = op_wd[li];
                    end else begin
                        lsb_req = 1'b0;
                    end
                end
                wait_idle();
            end
        end
        rnd_mode = 1'b0;
        rdy = 1'b1;
        io_buffer_full = 1'b0;
        finish_tb();
    end
endmodule
